// File: rtl/ram_responder.sv
// Word-addressed RAM slave for the MemoryInterface handshake.
// Answers read, write and combined requests after a fixed latency.
module ram_responder #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WIDTH   = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     readEnabled,
  input  logic                     writeEnabled,
  input  logic [DATA_WIDTH-1:0]    dataOut,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     functionComplete,
  output logic [15:0]              accessCount
);

  localparam int CW = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CW-1:0]          count;
  logic [CW-1:0]          countNext;
  logic [DEPTH_WIDTH-1:0] latAddr;
  logic [DATA_WIDTH-1:0]  latData;
  logic                   latRead;
  logic                   latWrite;

  logic anyEn;
  logic accept;
  logic commit;
  logic finish;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_WIDTH];

  // Upper address bits are deliberately ignored: addresses wrap.
  logic unusedAddr;
  assign unusedAddr = ^address[ADDRESS_WIDTH-1:DEPTH_WIDTH];

  assign anyEn = readEnabled | writeEnabled;

  always_comb begin
    stateNext = state;
    countNext = count;
    accept    = 1'b0;
    commit    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyEn) begin
          accept    = 1'b1;
          stateNext = BUSY;
          countNext = writeEnabled ? CW'(WRITE_LATENCY - 1)
                                   : CW'(READ_LATENCY - 1);
        end
      end
      BUSY: begin
        // Withdrawn enables abort before anything is committed.
        if (!anyEn) begin
          stateNext = IDLE;
        end else if (count == '0) begin
          commit    = 1'b1;
          stateNext = DONE;
        end else begin
          countNext = count - 1'b1;
        end
      end
      DONE: begin
        if (!anyEn) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      latAddr          <= '0;
      latData          <= '0;
      latRead          <= 1'b0;
      latWrite         <= 1'b0;
      dataIn           <= '0;
      functionComplete <= 1'b0;
      accessCount      <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (accept) begin
        latAddr  <= address[DEPTH_WIDTH-1:0];
        latData  <= dataOut;
        latRead  <= readEnabled;
        latWrite <= writeEnabled;
      end
      if (commit) begin
        functionComplete <= 1'b1;
        accessCount      <= accessCount + 1'b1;
        // Combined requests forward the write data.
        if (latRead) begin
          dataIn <= latWrite ? latData : mem[latAddr];
        end
      end
      if (finish) begin
        functionComplete <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (commit && latWrite) begin
      mem[latAddr] <= latData;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder.
// Model predicts data/count per request; checks at negedge.
module tb_ram_responder;

  localparam int RL = 4;
  localparam int WL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        readEnabled;
  logic        writeEnabled;
  logic [31:0] dataOut;
  logic [31:0] dataIn;
  logic        functionComplete;
  logic [15:0] accessCount;

  ram_responder #(
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH(32),
    .DEPTH_WIDTH(10),
    .READ_LATENCY(RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .readEnabled(readEnabled),
    .writeEnabled(writeEnabled),
    .dataOut(dataOut),
    .dataIn(dataIn),
    .functionComplete(functionComplete),
    .accessCount(accessCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [15:0] cnt;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] modelMem[int];
  logic [31:0] modelDataIn;
  int          modelCount;
  int          compared;
  int          mismatched;

  // Drives a request at a negedge and records the expected result.
  // Acceptance is the next edge k; completion is visible at the
  // negedge after edge k+L, i.e. L+1 negedges later.
  task automatic issue(input logic [15:0] a, input logic [31:0] d,
                       input logic rd, input logic wr);
    exp_t e;
    int   idx;
    idx = int'(a[9:0]);
    if (wr) modelMem[idx] = d;
    if (rd) modelDataIn = wr ? d : modelMem[idx];
    modelCount = (modelCount + 1) % 65536;
    e.data = modelDataIn;
    e.cnt  = 16'(modelCount);
    e.lat  = (wr ? WL : RL) + 1;
    sb.push_back(e);
    address      = a;
    dataOut      = d;
    readEnabled  = rd;
    writeEnabled = wr;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (functionComplete === 1'b1) break;
    end
  endtask

  task automatic dropEnables();
    readEnabled  = 1'b0;
    writeEnabled = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    readEnabled  = 1'b0;
    writeEnabled = 1'b0;
    address      = '0;
    dataOut      = '0;
    repeat (2) @(negedge clock);
    compared++;
    if (dataIn !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_dataIn got %h want 0", dataIn);
    end
    compared++;
    if (functionComplete !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_fc got %b want 0", functionComplete);
    end
    compared++;
    if (accessCount !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_count got %h want 0", accessCount);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Table of requests, each completed and released in turn.
  task automatic test_sequence(input string name,
                               input logic [15:0] a [],
                               input logic [31:0] d [],
                               input logic rd [], input logic wr []);
    int   n;
    exp_t e;
    for (int i = 0; i < a.size(); i++) begin
      issue(a[i], d[i], rd[i], wr[i]);
      waitDone(n);
      e = sb.pop_front();
      compared++;
      if (n !== e.lat) begin
        mismatched++;
        $display("FAIL %s[%0d]_latency got %0d want %0d",
                 name, i, n, e.lat);
      end
      compared++;
      if (dataIn !== e.data) begin
        mismatched++;
        $display("FAIL %s[%0d]_data got %h want %h",
                 name, i, dataIn, e.data);
      end
      compared++;
      if (accessCount !== e.cnt) begin
        mismatched++;
        $display("FAIL %s[%0d]_count got %h want %h",
                 name, i, accessCount, e.cnt);
      end
      dropEnables();
    end
  endtask

  task automatic test_write_read();
    test_sequence("write_read", '{16'h0012, 16'h0012},
                  '{32'hDEADBEEF, 32'h0}, '{1'b0, 1'b1}, '{1'b1, 1'b0});
  endtask

  task automatic test_combined();
    test_sequence("combined", '{16'h03FF, 16'h03FF},
                  '{32'h000000A5, 32'h0}, '{1'b1, 1'b1}, '{1'b1, 1'b0});
  endtask

  task automatic test_wrap();
    test_sequence("wrap", '{16'h0405, 16'h0005},
                  '{32'h00000011, 32'h0}, '{1'b0, 1'b1}, '{1'b1, 1'b0});
  endtask

  task automatic test_abort();
    bit sawFc;
    test_sequence("abort_pre", '{16'h0020}, '{32'h00001234},
                  '{1'b0}, '{1'b1});
    address      = 16'h0020;
    dataOut      = 32'h00000055;
    writeEnabled = 1'b1;
    readEnabled  = 1'b0;
    repeat (3) @(negedge clock);
    readEnabled  = 1'b0;
    writeEnabled = 1'b0;
    sawFc = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (functionComplete !== 1'b0) sawFc = 1'b1;
    end
    compared++;
    if (sawFc !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_fc got 1 want 0");
    end
    compared++;
    if (accessCount !== 16'(modelCount)) begin
      mismatched++;
      $display("FAIL abort_count got %h want %h", accessCount,
               16'(modelCount));
    end
    compared++;
    if (dataIn !== modelDataIn) begin
      mismatched++;
      $display("FAIL abort_dataIn got %h want %h", dataIn, modelDataIn);
    end
    test_sequence("abort_post", '{16'h0020}, '{32'h0}, '{1'b1}, '{1'b0});
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    bit   dropped;
    issue(16'h0100, 32'hCAFE0001, 1'b0, 1'b1);
    waitDone(n);
    e = sb.pop_front();
    compared++;
    if (n !== e.lat) begin
      mismatched++;
      $display("FAIL hold_latency got %0d want %0d", n, e.lat);
    end
    dropped = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (functionComplete !== 1'b1) dropped = 1'b1;
    end
    compared++;
    if (dropped !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_fc got dropped want held");
    end
    dropEnables();
    compared++;
    if (functionComplete !== 1'b0) begin
      mismatched++;
      $display("FAIL release_fc got %b want 0", functionComplete);
    end
    // Re-request right away: accepted on the edge after release.
    issue(16'h0100, 32'h0, 1'b1, 1'b0);
    waitDone(n);
    e = sb.pop_front();
    compared++;
    if (n !== e.lat) begin
      mismatched++;
      $display("FAIL b2b_latency got %0d want %0d", n, e.lat);
    end
    compared++;
    if (dataIn !== e.data) begin
      mismatched++;
      $display("FAIL b2b_data got %h want %h", dataIn, e.data);
    end
    compared++;
    if (accessCount !== e.cnt) begin
      mismatched++;
      $display("FAIL b2b_count got %h want %h", accessCount, e.cnt);
    end
    dropEnables();
  endtask

  task automatic test_reset_mid_busy();
    int   n;
    exp_t e;
    address      = 16'h0012;
    dataOut      = 32'h00000077;
    writeEnabled = 1'b1;
    readEnabled  = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    compared++;
    if (functionComplete !== 1'b0 || dataIn !== 32'h0 ||
        accessCount !== 16'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs got fc=%b d=%h c=%h want 0/0/0",
               functionComplete, dataIn, accessCount);
    end
    modelCount  = 0;
    modelDataIn = 32'h0;
    writeEnabled = 1'b0;
    @(negedge clock);
    // Request held across reset release is taken at the next edge.
    issue(16'h0012, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;
    waitDone(n);
    e = sb.pop_front();
    compared++;
    if (n !== e.lat) begin
      mismatched++;
      $display("FAIL postreset_latency got %0d want %0d", n, e.lat);
    end
    compared++;
    if (dataIn !== e.data) begin
      mismatched++;
      $display("FAIL postreset_data got %h want %h", dataIn, e.data);
    end
    compared++;
    if (accessCount !== e.cnt) begin
      mismatched++;
      $display("FAIL postreset_count got %h want %h", accessCount, e.cnt);
    end
    dropEnables();
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    modelCount  = 0;
    modelDataIn = 32'h0;
    test_reset();
    test_write_read();
    test_combined();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
